bsg_nonsynth_arr_capture: RTL and testbench

//  Capture-side counterpart of the DPI parameter ROM. The ROM presents a constant array for a host to read.

---
 rtl/bsg_nonsynth_arr_capture.sv | 152 +++++++++++++++
 tb/tb_bsg_nonsynth_arr_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_arr_capture.sv
// Captures a valid/ready word stream into an els_p-entry array and exposes the
// captured words, oldest first, through a combinational read port.
module bsg_nonsynth_arr_capture #(
  parameter int width_p = 32,
  parameter int els_p   = 4,
  parameter int wrap_p  = 0,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int cnt_w_lp  = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,
  input  logic [lg_els_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o,
  output logic [cnt_w_lp-1:0]  count_o,
  output logic                 full_o,
  output logic                 overflow_o
);

  if (els_p < 2) begin : g_els_check
    $error("bsg_nonsynth_arr_capture: els_p must be >= 2");
  end

  // one extra bit so oldest + r_addr_i never overflows before the modulo
  localparam int sum_w_lp = lg_els_lp + 1;
  localparam logic                 wrap_en_lp  = (wrap_p != 0);
  localparam logic [lg_els_lp-1:0] ptr_last_lp = lg_els_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0]  cnt_max_lp  = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0]  cnt_last_lp = cnt_w_lp'(els_p - 1);
  localparam logic [sum_w_lp-1:0]  els_sum_lp  = sum_w_lp'(els_p);

  typedef enum logic [1:0] {
    e_empty = 2'd0,
    e_fill  = 2'd1,
    e_full  = 2'd2
  } state_e;

  state_e               state_r, state_next_s;
  logic [cnt_w_lp-1:0]  count_r, count_next_s;
  logic [lg_els_lp-1:0] wptr_r, wptr_next_s;
  logic                 ovf_r, ovf_next_s;
  logic                 ready_s, accept_s, lost_s, is_full_s;
  logic [width_p-1:0]   mem_r [els_p];

  logic [lg_els_lp-1:0] oldest_s;
  logic [sum_w_lp-1:0]  sum_s, phys_s;
  logic                 in_range_s;

  function automatic logic [lg_els_lp-1:0] wptr_inc(input logic [lg_els_lp-1:0] p);
    if (p == ptr_last_lp) begin
      return '0;
    end else begin
      return p + lg_els_lp'(1);
    end
  endfunction

  assign is_full_s = (state_r == e_full);
  assign ready_s   = ~clear_i & (~is_full_s | wrap_en_lp);
  assign accept_s  = v_i & ready_s;
  // in wrap mode a loss is an overwrite; otherwise it is a stalled producer
  assign lost_s    = is_full_s & (wrap_en_lp ? accept_s : v_i);

  assign ready_o    = ready_s;
  assign count_o    = count_r;
  assign full_o     = is_full_s;
  assign overflow_o = ovf_r;

  // next-state decode for the capture FSM, pointer, count and sticky overflow
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    wptr_next_s  = wptr_r;
    ovf_next_s   = ovf_r;
    if (clear_i) begin
      state_next_s = e_empty;
      count_next_s = '0;
      wptr_next_s  = '0;
      ovf_next_s   = 1'b0;
    end else begin
      if (accept_s) begin
        wptr_next_s = wptr_inc(wptr_r);
        if (count_r != cnt_max_lp) begin
          count_next_s = count_r + cnt_w_lp'(1);
        end else begin
          count_next_s = count_r;
        end
        case (state_r)
          e_empty: state_next_s = e_fill;
          e_fill:  state_next_s = (count_r == cnt_last_lp) ? e_full : e_fill;
          e_full:  state_next_s = e_full;
          default: state_next_s = e_empty;
        endcase
      end else begin
        state_next_s = state_r;
        count_next_s = count_r;
        wptr_next_s  = wptr_r;
      end
      if (lost_s) begin
        ovf_next_s = 1'b1;
      end else begin
        ovf_next_s = ovf_r;
      end
    end
  end

  // capture FSM state and its registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_empty;
      count_r <= '0;
      wptr_r  <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      wptr_r  <= wptr_next_s;
      ovf_r   <= ovf_next_s;
    end
  end

  // capture storage; clear_i leaves contents alone since count hides them
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_r[i] <= '0;
      end
    end else if (accept_s) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // logical-to-physical read mapping with a single conditional subtract
  always_comb begin
    oldest_s   = is_full_s ? wptr_r : '0;
    sum_s      = sum_w_lp'(oldest_s) + sum_w_lp'(r_addr_i);
    in_range_s = (sum_w_lp'(r_addr_i) < sum_w_lp'(count_r));
    if (sum_s >= els_sum_lp) begin
      phys_s = sum_s - els_sum_lp;
    end else begin
      phys_s = sum_s;
    end
    if (in_range_s) begin
      r_data_o = mem_r[phys_s[lg_els_lp-1:0]];
    end else begin
      r_data_o = '0;
    end
  end

endmodule

// File: tb/tb_bsg_nonsynth_arr_capture.sv
// Scoreboard bench for bsg_nonsynth_arr_capture: three instances (4/no-wrap,
// 4/wrap, 3/wrap) share inputs; v_i is steered to one instance at a time.
module tb_bsg_nonsynth_arr_capture;

  localparam int F_READY = 0;
  localparam int F_COUNT = 1;
  localparam int F_FULL  = 2;
  localparam int F_OVF   = 3;
  localparam int F_RDATA = 4;

  typedef struct {
    int          dut;
    int          fld;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk, rst, clear, v;
  logic [31:0] data;
  logic [1:0]  r_addr;
  int          sel;

  logic        v0, v1, v2;
  logic        ready0, ready1, ready2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [2:0]  count0, count1;
  logic [1:0]  count2;
  logic        full0, full1, full2;
  logic        ovf0, ovf1, ovf2;

  chk_t        chk_q[$];
  logic [31:0] acc_q[$];
  chk_t        mon_c;
  logic [31:0] mon_act, mon_exp;
  int          checks = 0;
  int          errors = 0;

  assign v0 = v & (sel == 0);
  assign v1 = v & (sel == 1);
  assign v2 = v & (sel == 2);

  bsg_nonsynth_arr_capture #(.width_p(32), .els_p(4), .wrap_p(0)) u_nw4 (
    .clk_i(clk), .reset_i(rst), .clear_i(clear), .v_i(v0), .data_i(data),
    .ready_o(ready0), .r_addr_i(r_addr), .r_data_o(rdata0), .count_o(count0),
    .full_o(full0), .overflow_o(ovf0));

  bsg_nonsynth_arr_capture #(.width_p(32), .els_p(4), .wrap_p(1)) u_w4 (
    .clk_i(clk), .reset_i(rst), .clear_i(clear), .v_i(v1), .data_i(data),
    .ready_o(ready1), .r_addr_i(r_addr), .r_data_o(rdata1), .count_o(count1),
    .full_o(full1), .overflow_o(ovf1));

  bsg_nonsynth_arr_capture #(.width_p(32), .els_p(3), .wrap_p(1)) u_w3 (
    .clk_i(clk), .reset_i(rst), .clear_i(clear), .v_i(v2), .data_i(data),
    .ready_o(ready2), .r_addr_i(r_addr), .r_data_o(rdata2), .count_o(count2),
    .full_o(full2), .overflow_o(ovf2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] actual(input int d, input int f);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    case (d)
      0: case (f)
           F_READY: r = 32'(ready0);
           F_COUNT: r = 32'(count0);
           F_FULL:  r = 32'(full0);
           F_OVF:   r = 32'(ovf0);
           default: r = rdata0;
         endcase
      1: case (f)
           F_READY: r = 32'(ready1);
           F_COUNT: r = 32'(count1);
           F_FULL:  r = 32'(full1);
           F_OVF:   r = 32'(ovf1);
           default: r = rdata1;
         endcase
      default: case (f)
           F_READY: r = 32'(ready2);
           F_COUNT: r = 32'(count2);
           F_FULL:  r = 32'(full2);
           F_OVF:   r = 32'(ovf2);
           default: r = rdata2;
         endcase
    endcase
    return r;
  endfunction

  function automatic logic sel_accept();
    case (sel)
      0:       return v0 & ready0;
      1:       return v1 & ready1;
      default: return v2 & ready2;
    endcase
  endfunction

  // Monitor: away from the active edge, score accepts and pending output checks.
  always @(negedge clk) begin
    if (sel_accept()) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL accept dut%0d: accepted %0h, required no accept", sel, data);
      end else begin
        mon_exp = acc_q.pop_front();
        if (data !== mon_exp) begin
          errors++;
          $display("FAIL accept dut%0d: accepted %0h, required %0h", sel, data, mon_exp);
        end
      end
    end
    while (chk_q.size() != 0) begin
      mon_c   = chk_q.pop_front();
      mon_act = actual(mon_c.dut, mon_c.fld);
      checks++;
      if (mon_act !== mon_c.exp) begin
        errors++;
        $display("FAIL %s: got %0h, required %0h", mon_c.name, mon_act, mon_c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int f, input logic [31:0] e, input string n);
    chk_t c;
    c.dut  = d;
    c.fld  = f;
    c.exp  = e;
    c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic status(input int d, input logic [31:0] rdy, input logic [31:0] cnt,
                        input logic [31:0] ful, input logic [31:0] ovf, input string tag);
    push(d, F_READY, rdy, {tag, "_ready"});
    push(d, F_COUNT, cnt, {tag, "_count"});
    push(d, F_FULL,  ful, {tag, "_full"});
    push(d, F_OVF,   ovf, {tag, "_overflow"});
  endtask

  task automatic send(input logic [31:0] w, input logic expect_acc);
    v    = 1'b1;
    data = w;
    if (expect_acc) acc_q.push_back(w);
    tick();
  endtask

  task automatic read(input int d, input logic [1:0] a, input logic [31:0] e, input string n);
    v      = 1'b0;
    r_addr = a;
    push(d, F_RDATA, e, n);
    tick();
  endtask

  task automatic do_reset();
    v     = 1'b0;
    clear = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    clear  = 1'b0;
    v      = 1'b0;
    data   = 32'h0;
    r_addr = 2'd0;
    sel    = 0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state after idling
    repeat (3) tick();
    status(0, 32'd1, 32'd0, 32'd0, 32'd0, "t1_nw4");
    status(2, 32'd1, 32'd0, 32'd0, 32'd0, "t1_w3");
    for (int a = 0; a < 4; a++) read(0, 2'(a), 32'h0, "t1_rdata");

    // 2: no-wrap fill then stall
    sel = 0;
    for (int k = 0; k < 4; k++) send(32'd10 + 32'(k), 1'b1);
    send(32'd14, 1'b0);
    v = 1'b1;
    status(0, 32'd0, 32'd4, 32'd1, 32'd1, "t2_full");
    tick();
    read(0, 2'd0, 32'd10, "t2_r0");
    read(0, 2'd1, 32'd11, "t2_r1");
    read(0, 2'd2, 32'd12, "t2_r2");
    read(0, 2'd3, 32'd13, "t2_r3");
    // clear drops ready at once and wipes the sticky overflow next cycle
    clear = 1'b1;
    push(0, F_READY, 32'd0, "t2_clear_ready");
    tick();
    clear = 1'b0;
    status(0, 32'd1, 32'd0, 32'd0, 32'd0, "t2_after_clear");
    tick();

    // 3: wrap mode overwrites oldest
    do_reset();
    sel = 1;
    for (int k = 1; k <= 6; k++) send(32'(k), 1'b1);
    v = 1'b0;
    status(1, 32'd1, 32'd4, 32'd1, 32'd1, "t3_w4");
    tick();
    read(1, 2'd0, 32'd3, "t3_r0");
    read(1, 2'd1, 32'd4, "t3_r1");
    read(1, 2'd2, 32'd5, "t3_r2");
    read(1, 2'd3, 32'd6, "t3_r3");

    // 4: bubbles in the valid stream
    do_reset();
    sel = 0;
    send(32'hA5A5_0001, 1'b1);
    v = 1'b0; data = 32'hDEAD_BEEF; tick();
    send(32'hA5A5_0002, 1'b1);
    send(32'hA5A5_0003, 1'b1);
    v = 1'b0;
    push(0, F_COUNT, 32'd3, "t4_count");
    push(0, F_FULL,  32'd0, "t4_full");
    tick();
    read(0, 2'd0, 32'hA5A5_0001, "t4_r0");
    read(0, 2'd1, 32'hA5A5_0002, "t4_r1");
    read(0, 2'd2, 32'hA5A5_0003, "t4_r2");
    read(0, 2'd3, 32'h0,         "t4_r3_beyond_count");

    // 5: clear beats a simultaneous valid
    do_reset();
    sel = 0;
    send(32'd21, 1'b1);
    send(32'd22, 1'b1);
    clear = 1'b1;
    push(0, F_READY, 32'd0, "t5_clear_ready");
    send(32'd23, 1'b0);
    clear = 1'b0;
    v     = 1'b0;
    push(0, F_COUNT, 32'd0, "t5_count");
    push(0, F_OVF,   32'd0, "t5_overflow");
    tick();
    send(32'd24, 1'b1);
    push(0, F_COUNT, 32'd1, "t5_count_after");
    read(0, 2'd0, 32'd24, "t5_r0");

    // 6: non-power-of-2 wrap, then asynchronous reset between edges
    do_reset();
    sel = 2;
    for (int k = 7; k <= 10; k++) send(32'(k), 1'b1);
    v = 1'b0;
    status(2, 32'd1, 32'd3, 32'd1, 32'd1, "t6_w3");
    tick();
    read(2, 2'd0, 32'd8,  "t6_r0");
    read(2, 2'd1, 32'd9,  "t6_r1");
    read(2, 2'd2, 32'd10, "t6_r2");
    #1;
    rst = 1'b1;
    push(2, F_COUNT, 32'd0, "t6_async_count");
    push(2, F_FULL,  32'd0, "t6_async_full");
    push(2, F_OVF,   32'd0, "t6_async_overflow");
    push(2, F_RDATA, 32'd0, "t6_async_rdata");
    tick();
    rst = 1'b0;
    tick();
    tick();

    checks++;
    if (acc_q.size() != 0) begin
      errors++;
      $display("FAIL accept_drain: %0d words never accepted, required 0", acc_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
